dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//   Responder side of the pipeline's data-memory port: a word-addressed data RAM behind a valid/ready request handshake.
//   Serves one load/store from the MEM stage at a time, with a fixed, configurable access latency.
//   The MEM stage issues requests and stalls the pipeline until resp_valid_o arrives.
// PARAMETERS
//   DEPTH    256  number of 32-bit words; power of two, >= 2
//   LATENCY  2    cycles from request accept to response; >= 1
// PORTS
//   clk_i         in   1   clock; all logic on rising edge
//   rst_i         in   1   synchronous reset, active-high
//   req_valid_i   in   1   request present
//   req_ready_o   out  1   responder can accept a request this cycle
//   req_we_i      in   1   1 = store, 0 = load
//   req_addr_i    in   32  byte address
//   req_wdata_i   in   32  store data
//   resp_valid_o  out  1   one-cycle pulse: access complete
//   resp_rdata_o  out  32  load data; 0 for stores and errors
//   resp_err_o    out  1   misaligned access; valid with resp_valid_o
// BEHAVIOUR
//   - Reset: state IDLE, req_ready_o=0 during the reset cycle, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0.
//     RAM contents are not reset.
//   - States: IDLE -> WAIT -> RESP -> IDLE.
//     - IDLE: req_ready_o=1. On req_valid_i, capture we/addr/wdata and load cnt=LATENCY-1.
//       If LATENCY==1, go straight to RESP; otherwise go to WAIT.
//     - WAIT: req_ready_o=0. Decrement cnt; go to RESP when cnt reaches 0.
//     - RESP: resp_valid_o=1 for exactly one cycle, then IDLE. req_ready_o=0.
//   - Latency: request accepted in cycle N -> resp_valid_o high in cycle N+LATENCY.
//     Next accept no earlier than N+LATENCY+1.
//   - Request inputs are ignored outside IDLE; no queueing. The response has no backpressure.
//   - Index = addr[2 +: log2(DEPTH)]. Upper address bits are ignored, so addresses wrap modulo DEPTH*4.
//   - Store: RAM written on the edge that enters RESP. resp_rdata_o=0.
//   - Load: resp_rdata_o = RAM[index] as of entry to RESP. Holds 0 outside RESP.
//   - Read-after-write: a load accepted after a store's response sees the new data.
//   - Reset mid-operation: transaction aborted, no response issued.
//     A store that has not yet entered RESP is not committed.
// CONFIGURATION
//   DMEM_ALIGN_CHECK_EN
//     - Defined: addr[1:0]!=0 gives resp_err_o=1 and resp_rdata_o=0, with the same latency.
//       A misaligned store does not write the RAM.
//     - Undefined: addr[1:0] ignored; resp_err_o tied 0.
// STRUCTURE
//   - Package dmem_pkg: state encoding (IDLE/WAIT/RESP), DATA_W=32, ADDR_W=32 constants.
//   - Sub-module dmem_array: DEPTH x 32 storage, synchronous write, one read port.
//   - FSM, latency counter and request capture registers stay in dmem_responder.
// TESTING
//   - Reset: hold rst_i 2 cycles -> req_ready_o=0 and resp_valid_o=0 during reset; req_ready_o=1 the cycle after release.
//   - Store then load: store 0xDEADBEEF to 0x10; after its response, load 0x10 -> resp_rdata_o=0xDEADBEEF,
//     resp_valid_o exactly LATENCY cycles after each accept.
//   - Busy: drive req_valid_i continuously with LATENCY=3 -> accepts every 4 cycles.
//     Requests presented while busy do not change the RAM or the response.
//   - Wrap: DEPTH=256, store 0x55 to 0x400, load 0x000 -> 0x55.
//   - Reset mid-op: accept store 0x1234 to 0x20; assert rst_i in the WAIT state -> no resp_valid_o.
//     A later load of 0x20 returns the old value.
//   - Align (macro defined): store to 0x22 -> resp_err_o=1, RAM unchanged.
//     Without the macro: same store writes word 0x20 and resp_err_o=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants and FSM state encoding for the data-memory responder.
package dmem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W data RAM: synchronous write, one registered read port.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[idx_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time with fixed LATENCY.
// Optional misalignment checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              resp_valid_o,
    output logic [DATA_W-1:0] resp_rdata_o,
    output logic              resp_err_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    dmem_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              we_q;
    logic              err_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] wdata_q;

    logic              accept;
    logic              enter_resp;
    logic              in_err;
    logic              txn_we;
    logic              txn_err;
    logic [IDX_W-1:0]  txn_idx;
    logic [DATA_W-1:0] txn_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;
    logic              unused_addr_bits;

`ifdef DMEM_ALIGN_CHECK_EN
    assign in_err = (req_addr_i[1:0] != 2'b00);
`else
    assign in_err = 1'b0;
`endif

    assign unused_addr_bits = ^{req_addr_i[ADDR_W-1:IDX_W+2], req_addr_i[1:0]};

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // With LATENCY==1 the RAM access happens on the accept edge itself, so the
    // transaction fields come straight from the request port while in IDLE.
    assign txn_we    = (state_q == S_IDLE) ? req_we_i : we_q;
    assign txn_err   = (state_q == S_IDLE) ? in_err : err_q;
    assign txn_idx   = (state_q == S_IDLE) ? req_addr_i[2 +: IDX_W] : idx_q;
    assign txn_wdata = (state_q == S_IDLE) ? req_wdata_i : wdata_q;

    // Reset wins over an in-flight store so nothing is committed.
    assign mem_we = enter_resp && !rst_i && txn_we && !txn_err;
    assign mem_re = enter_resp && !rst_i && !txn_we && !txn_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q   <= CNT_W'(LATENCY - 1);
                we_q    <= req_we_i;
                err_q   <= in_err;
                idx_q   <= req_addr_i[2 +: IDX_W];
                wdata_q <= req_wdata_i;
            end else if (state_q == S_WAIT) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .idx_i   (txn_idx),
        .wdata_i (txn_wdata),
        .rdata_o (mem_rdata)
    );

    assign req_ready_o  = (state_q == S_IDLE) && !rst_i;
    assign resp_valid_o = (state_q == S_RESP);
    assign resp_rdata_o = (resp_valid_o && !we_q && !err_q) ? mem_rdata : '0;

`ifdef DMEM_ALIGN_CHECK_EN
    assign resp_err_o = resp_valid_o && err_q;
`else
    assign resp_err_o = 1'b0;
`endif

endmodule
